// File: rtl/pox_pkg.sv
// Shared definitions for the pulse-oximeter acquisition scheduler.
//  - One-hot state encoding for the 7-state phase sequencer.
//  - AFE setting widths (DC compensation, PGA gain) and ADC sample width.
//  - load_val(): converts a phase duration in cycles into the 8-bit
//    down-counter reload value. The counter expires at 0, so the reload is
//    the duration minus one.
package pox_pkg;

    localparam int DC_W    = 7;
    localparam int PGA_W   = 4;
    localparam int ADC_W   = 8;
    localparam int STATE_W = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 7'b000_0001,
        ST_RED_SETTLE = 7'b000_0010,
        ST_RED_ACQ    = 7'b000_0100,
        ST_GAP1       = 7'b000_1000,
        ST_IR_SETTLE  = 7'b001_0000,
        ST_IR_ACQ     = 7'b010_0000,
        ST_GAP2       = 7'b100_0000
    } state_e;

    function automatic logic [7:0] load_val(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/pox_phase_avg.sv
// N-sample accumulator shared by the RED and IR acquisition phases.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset
//  clr         synchronous clear of accumulator and sample count
//  add         accumulate 'sample' on this edge
//  sample      ADC sample
//  avg         truncated mean including the sample presented this cycle
//  done        high in the cycle whose sample is the N-th one; the
//              accumulator clears itself on that same edge
module pox_phase_avg
    import pox_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg,
    output logic             done
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int N     = 1 << AVG_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_full;

    // The mean is taken from the running sum plus the current sample so the
    // result is ready on the very edge that consumes the last sample.
    assign sum_full = acc_q + ACC_W'(sample);
    assign avg      = sum_full[ACC_W-1:AVG_LOG2];
    assign done     = add && (cnt_q == CNT_W'(N - 1));

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            if (done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_full;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pox_acq_scheduler.sv
// Time-multiplexed RED/IR acquisition sequencer for the pulse-oximeter AFE.
// Each frame: RED settle -> RED average -> dark gap -> IR settle ->
// IR average -> dark gap, repeated while EN is high. Frames always complete.
// Ports:
//  CLK, rst_n                 clock, asynchronous active-low reset
//  EN                         level-sensitive run request
//  RED_/IR_ DC_Set, PGA_Set   calibrated per-channel AFE settings
//  ADC                        AFE sample, valid every cycle
//  LED_RED, LED_IR            LED enables (never both high)
//  DC_Comp, PGA_Gain          settings driven to the AFE for the active LED
//  RED_/IR_ ADC_Value, _Valid averaged results and one-cycle update strobes
//  Busy                       high whenever the sequencer is not idle
//  Frame_Cnt                  completed frame count, wraps at 255
module pox_acq_scheduler
    import pox_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2,
    parameter int DARK_CYC   = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [DC_W-1:0]  RED_DC_Set,
    input  logic [PGA_W-1:0] RED_PGA_Set,
    input  logic [DC_W-1:0]  IR_DC_Set,
    input  logic [PGA_W-1:0] IR_PGA_Set,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic             RED_Valid,
    output logic             IR_Valid,
    output logic             Busy,
    output logic [7:0]       Frame_Cnt
);

    localparam logic [7:0] SETTLE_LEN = load_val(SETTLE_CYC);
    localparam logic [7:0] ACQ_LEN    = load_val(1 << AVG_LOG2);
    localparam logic [7:0] DARK_LEN   = load_val(DARK_CYC);

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic [DC_W-1:0]  red_dc_q, red_dc_d, ir_dc_q, ir_dc_d;
    logic [PGA_W-1:0] red_pga_q, red_pga_d, ir_pga_q, ir_pga_d;

    logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
    logic [DC_W-1:0]  dc_comp_q, dc_comp_d;
    logic [PGA_W-1:0] pga_gain_q, pga_gain_d;
    logic [ADC_W-1:0] red_val_q, red_val_d, ir_val_q, ir_val_d;
    logic             red_valid_q, red_valid_d, ir_valid_q, ir_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic             in_acq, avg_done;
    logic [ADC_W-1:0] avg_val;
    logic             enter_red, red_sel, ir_sel, red_done, ir_done, gap2_exit;

    assign in_acq = (state_q == ST_RED_ACQ) || (state_q == ST_IR_ACQ);

    pox_phase_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk    (CLK),
        .rst_n  (rst_n),
        .clr    (!in_acq),
        .add    (in_acq),
        .sample (ADC),
        .avg    (avg_val),
        .done   (avg_done)
    );

    assign gap2_exit = (state_q == ST_GAP2) && (cnt_q == 8'd0);
    assign red_done  = (state_q == ST_RED_ACQ) && avg_done;
    assign ir_done   = (state_q == ST_IR_ACQ) && avg_done;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (EN)            state_d = ST_RED_SETTLE;
            ST_RED_SETTLE: if (cnt_q == 8'd0) state_d = ST_RED_ACQ;
            ST_RED_ACQ:    if (avg_done)      state_d = ST_GAP1;
            ST_GAP1:       if (cnt_q == 8'd0) state_d = ST_IR_SETTLE;
            ST_IR_SETTLE:  if (cnt_q == 8'd0) state_d = ST_IR_ACQ;
            ST_IR_ACQ:     if (avg_done)      state_d = ST_GAP2;
            ST_GAP2:       if (cnt_q == 8'd0) state_d = EN ? ST_RED_SETTLE : ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Phase-length down-counter: reloaded whenever the state changes
    // (including GAP2 -> RED_SETTLE back-to-back frames).
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_RED_SETTLE, ST_IR_SETTLE: cnt_d = SETTLE_LEN;
                ST_RED_ACQ, ST_IR_ACQ:       cnt_d = ACQ_LEN;
                ST_GAP1, ST_GAP2:            cnt_d = DARK_LEN;
                default:                     cnt_d = 8'd0;
            endcase
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Settings are sampled once per frame so mid-frame changes cannot mix
    // calibrations within a RED/IR pair.
    assign enter_red = (state_d == ST_RED_SETTLE) && (state_q != ST_RED_SETTLE);

    always_comb begin
        red_dc_d  = red_dc_q;
        red_pga_d = red_pga_q;
        ir_dc_d   = ir_dc_q;
        ir_pga_d  = ir_pga_q;
        if (enter_red) begin
            red_dc_d  = RED_DC_Set;
            red_pga_d = RED_PGA_Set;
            ir_dc_d   = IR_DC_Set;
            ir_pga_d  = IR_PGA_Set;
        end
    end

    // Outputs are computed from the next state so the registered outputs
    // line up with the state they describe. Using the *_d settings lets the
    // RED entry cycle already drive the freshly captured values.
    assign red_sel = (state_d == ST_RED_SETTLE) || (state_d == ST_RED_ACQ);
    assign ir_sel  = (state_d == ST_IR_SETTLE)  || (state_d == ST_IR_ACQ);

    always_comb begin
        led_red_d   = red_sel;
        led_ir_d    = ir_sel;
        dc_comp_d   = '0;
        pga_gain_d  = '0;
        if (red_sel) begin
            dc_comp_d  = red_dc_d;
            pga_gain_d = red_pga_d;
        end else if (ir_sel) begin
            dc_comp_d  = ir_dc_d;
            pga_gain_d = ir_pga_d;
        end
        red_val_d   = red_done ? avg_val : red_val_q;
        ir_val_d    = ir_done  ? avg_val : ir_val_q;
        red_valid_d = red_done;
        ir_valid_d  = ir_done;
        busy_d      = (state_d != ST_IDLE);
        frame_cnt_d = frame_cnt_q + {7'd0, gap2_exit};
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            red_dc_q    <= '0;
            red_pga_q   <= '0;
            ir_dc_q     <= '0;
            ir_pga_q    <= '0;
            led_red_q   <= 1'b0;
            led_ir_q    <= 1'b0;
            dc_comp_q   <= '0;
            pga_gain_q  <= '0;
            red_val_q   <= '0;
            ir_val_q    <= '0;
            red_valid_q <= 1'b0;
            ir_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            red_dc_q    <= red_dc_d;
            red_pga_q   <= red_pga_d;
            ir_dc_q     <= ir_dc_d;
            ir_pga_q    <= ir_pga_d;
            led_red_q   <= led_red_d;
            led_ir_q    <= led_ir_d;
            dc_comp_q   <= dc_comp_d;
            pga_gain_q  <= pga_gain_d;
            red_val_q   <= red_val_d;
            ir_val_q    <= ir_val_d;
            red_valid_q <= red_valid_d;
            ir_valid_q  <= ir_valid_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign DC_Comp       = dc_comp_q;
    assign PGA_Gain      = pga_gain_q;
    assign RED_ADC_Value = red_val_q;
    assign IR_ADC_Value  = ir_val_q;
    assign RED_Valid     = red_valid_q;
    assign IR_Valid      = ir_valid_q;
    assign Busy          = busy_q;
    assign Frame_Cnt     = frame_cnt_q;

endmodule

// File: tb/tb_pox_acq_scheduler.sv
// Self-checking bench for pox_acq_scheduler: a default instance and an
// AVG_LOG2=0 instance, both compared every cycle against a frame-position
// reference model, plus table vectors and directed corner sequences.
module tb_pox_acq_scheduler;

    localparam int S_CYC = 4;
    localparam int L_DEF = 2;
    localparam int D_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n, en, en0;
    logic [6:0] rdc, idc;
    logic [3:0] rpga, ipga;
    logic [7:0] adc;

    logic       led_r, led_i, rv, iv, busy;
    logic [6:0] dc;
    logic [3:0] pga;
    logic [7:0] rval, ival, fcnt;
    logic       z_led_r, z_led_i, z_rv, z_iv, z_busy;
    logic [6:0] z_dc;
    logic [3:0] z_pga;
    logic [7:0] z_rval, z_ival, z_fcnt;

    always #5 clk = ~clk;

    pox_acq_scheduler #(.SETTLE_CYC(S_CYC), .AVG_LOG2(L_DEF), .DARK_CYC(D_CYC)) dut (
        .CLK(clk), .rst_n(rst_n), .EN(en),
        .RED_DC_Set(rdc), .RED_PGA_Set(rpga), .IR_DC_Set(idc), .IR_PGA_Set(ipga),
        .ADC(adc), .LED_RED(led_r), .LED_IR(led_i), .DC_Comp(dc), .PGA_Gain(pga),
        .RED_ADC_Value(rval), .IR_ADC_Value(ival), .RED_Valid(rv), .IR_Valid(iv),
        .Busy(busy), .Frame_Cnt(fcnt));

    pox_acq_scheduler #(.SETTLE_CYC(S_CYC), .AVG_LOG2(0), .DARK_CYC(D_CYC)) dut0 (
        .CLK(clk), .rst_n(rst_n), .EN(en0),
        .RED_DC_Set(rdc), .RED_PGA_Set(rpga), .IR_DC_Set(idc), .IR_PGA_Set(ipga),
        .ADC(adc), .LED_RED(z_led_r), .LED_IR(z_led_i), .DC_Comp(z_dc), .PGA_Gain(z_pga),
        .RED_ADC_Value(z_rval), .IR_ADC_Value(z_ival), .RED_Valid(z_rv), .IR_Valid(z_iv),
        .Busy(z_busy), .Frame_Cnt(z_fcnt));

    logic [39:0] dvec, zvec;
    assign dvec = {led_r, led_i, dc, pga, rval, ival, rv, iv, busy, fcnt};
    assign zvec = {z_led_r, z_led_i, z_dc, z_pga, z_rval, z_ival, z_rv, z_iv, z_busy, z_fcnt};

    // ---------------- reference model: position within a frame ----------------
    typedef struct {
        bit       run;
        int       pos;
        bit [6:0] rdc, idc;
        bit [3:0] rpga, ipga;
        int       sum;
        bit [7:0] rres, ires, frames;
        bit       rv, iv;
    } mdl_t;

    function automatic mdl_t mdl_step(mdl_t m, bit en_i, bit [6:0] rdc_i, bit [3:0] rpga_i,
                                      bit [6:0] idc_i, bit [3:0] ipga_i, bit [7:0] adc_i,
                                      int s, int l, int d);
        int n  = 1 << l;
        int p  = 2 * (s + n + d);
        int ra = s;
        int ia = 2 * s + n + d;
        mdl_t r = m;
        r.rv = 1'b0;
        r.iv = 1'b0;
        if (!m.run) begin
            if (en_i) begin
                r.run = 1'b1; r.pos = 0;
                r.rdc = rdc_i; r.rpga = rpga_i; r.idc = idc_i; r.ipga = ipga_i;
            end
        end else begin
            if (m.pos >= ra && m.pos < ra + n) begin
                r.sum = m.sum + int'(adc_i);
                if (m.pos == ra + n - 1) begin r.rres = 8'(r.sum >> l); r.rv = 1'b1; r.sum = 0; end
            end
            if (m.pos >= ia && m.pos < ia + n) begin
                r.sum = m.sum + int'(adc_i);
                if (m.pos == ia + n - 1) begin r.ires = 8'(r.sum >> l); r.iv = 1'b1; r.sum = 0; end
            end
            if (m.pos == p - 1) begin
                r.frames = m.frames + 8'd1;
                if (en_i) begin
                    r.pos = 0;
                    r.rdc = rdc_i; r.rpga = rpga_i; r.idc = idc_i; r.ipga = ipga_i;
                end else begin
                    r.run = 1'b0;
                end
            end else begin
                r.pos = m.pos + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [39:0] exp_vec(mdl_t m, int s, int l, int d);
        int n = 1 << l;
        bit lr, li;
        bit [6:0] edc;
        bit [3:0] epg;
        lr  = m.run && (m.pos < s + n);
        li  = m.run && (m.pos >= s + n + d) && (m.pos < 2 * s + 2 * n + d);
        edc = lr ? m.rdc  : (li ? m.idc  : 7'd0);
        epg = lr ? m.rpga : (li ? m.ipga : 4'd0);
        return {lr, li, edc, epg, m.rres, m.ires, m.rv, m.iv, m.run, m.frames};
    endfunction

    mdl_t m, m0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m  <= '{default: 0};
            m0 <= '{default: 0};
        end else begin
            m  <= mdl_step(m,  en,  rdc, rpga, idc, ipga, adc, S_CYC, L_DEF, D_CYC);
            m0 <= mdl_step(m0, en0, rdc, rpga, idc, ipga, adc, S_CYC, 0,     D_CYC);
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string nm, input logic [39:0] act, input logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_on) begin
            cmp("model_dut",  dvec, exp_vec(m,  S_CYC, L_DEF, D_CYC));
            cmp("model_dut0", zvec, exp_vec(m0, S_CYC, 0,     D_CYC));
            cmp("led_overlap", 40'({led_r & led_i, z_led_r & z_led_i}), 40'd0);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy || z_busy) && n < max_cyc) begin
            adc = 8'($urandom);
            tick();
            n++;
        end
        cmp("idle_reached", 40'({busy, z_busy}), 40'd0);
    endtask

    task automatic set_cfg(input logic [6:0] a, input logic [3:0] b,
                           input logic [6:0] c, input logic [3:0] d);
        rdc = a; rpga = b; idc = c; ipga = d;
    endtask

    typedef struct {
        bit [6:0]      rdc;
        bit [3:0]      rpga;
        bit [6:0]      idc;
        bit [3:0]      ipga;
        bit [3:0][7:0] rsmp;
        bit [3:0][7:0] ismp;
        bit [7:0]      er, ei;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [7:0] f0, prev_f;
        int last_rv, last_iv, rvc, ivc, frames_seen, cyc;
        bit wrap;

        tbl[0] = '{7'd20, 4'd3, 7'd45, 4'd7, {8'h80, 8'h80, 8'h80, 8'h80},
                   {8'h80, 8'h80, 8'h80, 8'h80}, 8'h80, 8'h80};
        tbl[1] = '{7'd5, 4'd1, 7'd100, 4'd15, {8'd14, 8'd12, 8'd11, 8'd10},
                   {8'd3, 8'd0, 8'd0, 8'd0}, 8'd11, 8'd0};
        tbl[2] = '{7'd127, 4'd15, 7'd0, 4'd0, {8'd255, 8'd255, 8'd255, 8'd255},
                   {8'd254, 8'd255, 8'd255, 8'd255}, 8'd255, 8'd254};
        tbl[3] = '{7'd1, 4'd2, 7'd3, 4'd4, {8'd4, 8'd3, 8'd2, 8'd1},
                   {8'd0, 8'd25, 8'd50, 8'd100}, 8'd2, 8'd43};

        en = 1'b0; en0 = 1'b0; adc = 8'd0; set_cfg(7'd0, 4'd0, 7'd0, 4'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        cmp("reset_state", dvec, 40'd0);
        cmp("reset_state_l0", zvec, 40'd0);
        chk_on = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        $display("reset: outputs cleared");

        // Table vectors: one EN pulse per frame, samples placed in ACQ cycles.
        for (int k = 0; k < 4; k++) begin
            f0 = fcnt;
            set_cfg(tbl[k].rdc, tbl[k].rpga, tbl[k].idc, tbl[k].ipga);
            en = 1'b1;
            tick();
            en = 1'b0;
            for (int c = 1; c <= 21; c++) begin
                if (c == 1) cmp("red_entry_dc", 40'({dc, pga}), 40'({tbl[k].rdc, tbl[k].rpga}));
                if (c == 2) cmp("red_leds", 40'({led_r, led_i}), 40'(2'b10));
                if (c == 8) cmp("red_no_early_valid", 40'(rv), 40'd0);
                if (c == 9) cmp("red_result", 40'({rv, rval}), 40'({1'b1, tbl[k].er}));
                if (c == 10) cmp("gap1_dark", 40'({led_r, led_i, dc, pga}), 40'd0);
                if (c == 12) cmp("ir_dc", 40'({led_i, dc, pga}), 40'({1'b1, tbl[k].idc, tbl[k].ipga}));
                if (c == 19) cmp("ir_result", 40'({iv, ival}), 40'({1'b1, tbl[k].ei}));
                if (c == 21) cmp("idle_frame", 40'({busy, fcnt}), 40'({1'b0, 8'(f0 + 8'd1)}));
                if (c >= 5 && c <= 8)        adc = tbl[k].rsmp[c - 5];
                else if (c >= 15 && c <= 18) adc = tbl[k].ismp[c - 15];
                else                         adc = 8'($urandom);
                tick();
            end
            $display("vector %0d: red=%0d ir=%0d frames=%0d", k, rval, ival, fcnt);
        end

        // AVG_LOG2=0 instance: the result is the single sample.
        en0 = 1'b1;
        tick();
        en0 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 6)  cmp("l0_red", 40'({z_rv, z_rval}), 40'({1'b1, 8'h5A}));
            if (c == 13) cmp("l0_ir",  40'({z_iv, z_ival}), 40'({1'b1, 8'hC3}));
            if (c == 15) cmp("l0_idle", 40'(z_busy), 40'd0);
            adc = (c == 5) ? 8'h5A : ((c == 12) ? 8'hC3 : 8'($urandom));
            tick();
        end
        $display("avg0: red=%0h ir=%0h", z_rval, z_ival);

        // Settings changed during IR_SETTLE only apply from the next frame.
        set_cfg(7'd11, 4'd2, 7'd22, 4'd4);
        en = 1'b1;
        tick();
        for (int c = 1; c <= 33; c++) begin
            if (c == 12) set_cfg(7'd99, 4'd9, 7'd66, 4'd6);
            if (c == 16) cmp("old_ir_cfg", 40'({dc, pga}), 40'({7'd22, 4'd4}));
            if (c == 21) cmp("new_red_cfg", 40'({led_r, dc, pga}), 40'({1'b1, 7'd99, 4'd9}));
            if (c == 32) cmp("new_ir_cfg", 40'({led_i, dc, pga}), 40'({1'b1, 7'd66, 4'd6}));
            if (c == 33) en = 1'b0;
            adc = 8'($urandom);
            tick();
        end
        wait_idle(40);
        $display("mid-frame settings: frames=%0d", fcnt);

        // Drop EN during GAP1: IR phase still completes.
        en = 1'b1;
        tick();
        for (int c = 1; c <= 22; c++) begin
            if (c == 10) en = 1'b0;
            if (c == 19) cmp("gap1_drop_ir_valid", 40'(iv), 40'd1);
            if (c == 21) cmp("gap1_drop_idle", 40'({busy, led_r, led_i}), 40'd0);
            if (c == 22) cmp("gap1_drop_stays", 40'(busy), 40'd0);
            adc = 8'($urandom);
            tick();
        end
        $display("en drop in gap1: ir=%0d busy=%0d", ival, busy);

        // Asynchronous reset in the middle of RED_ACQ.
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int c = 1; c < 6; c++) begin adc = 8'($urandom); tick(); end
        rst_n = 1'b0;
        #1;
        cmp("reset_mid_acq", dvec, 40'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cmp("no_strobe_after_reset", 40'({rv, iv, busy}), 40'd0);
            adc = 8'($urandom);
            tick();
        end
        $display("reset mid acq: outputs cleared");

        // EN held for 300 frames with settings churning underneath.
        en = 1'b1;
        prev_f = fcnt; last_rv = -1; last_iv = -1; rvc = 0; ivc = 0;
        frames_seen = 0; cyc = 0; wrap = 1'b0;
        while (frames_seen < 300 && cyc < 300 * 20 + 100) begin
            adc = 8'($urandom);
            if ($urandom_range(7) == 0)
                set_cfg(7'($urandom), 4'($urandom), 7'($urandom), 4'($urandom));
            tick();
            cyc++;
            if (rv) begin
                if (last_rv >= 0) cmp("red_period", 40'(cyc - last_rv), 40'd20);
                last_rv = cyc; rvc++;
            end
            if (iv) begin
                if (last_iv >= 0) cmp("ir_period", 40'(cyc - last_iv), 40'd20);
                last_iv = cyc; ivc++;
            end
            if (fcnt != prev_f) begin
                cmp("valids_per_frame", 40'({8'(rvc), 8'(ivc)}), 40'({8'd1, 8'd1}));
                if (prev_f == 8'd255 && fcnt == 8'd0) wrap = 1'b1;
                prev_f = fcnt; frames_seen++; rvc = 0; ivc = 0;
            end
        end
        cmp("frames_300", 40'(frames_seen), 40'd300);
        en = 1'b0;
        wait_idle(40);
        cmp("frame_wrap", 40'(wrap), 40'd1);
        $display("300 frames: frame_cnt=%0d wrapped=%0d", fcnt, wrap);

        // Random traffic on both instances, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) en  = ~en;
            if ($urandom_range(15) == 0) en0 = ~en0;
            adc = 8'($urandom);
            if ($urandom_range(3) == 0)
                set_cfg(7'($urandom), 4'($urandom), 7'($urandom), 4'($urandom));
            rst_n = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst_n = 1'b1; en = 1'b0; en0 = 1'b0;
        wait_idle(60);
        $display("random: frames=%0d frames0=%0d", fcnt, z_fcnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
